// File: rtl/apb_bus_arbiter.sv
// Two-requester round-robin arbiter in front of the APB master bus port.
// One transfer at a time. A watchdog completes stalled transfers with ERR_DATA.
module apb_bus_arbiter #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_transfer,
    input  logic        m0_write,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_transfer,
    input  logic        m1_write,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        bus_transfer,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    input  logic        err_clr,
    output logic        err,
    output logic        err_id
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          gnt, last, win;
    logic          rd_cap, to_cap;
    logic          clr0, clr1;

    logic          v0, v1, w0, w1;
    logic [31:0]   a0, a1, d0, d1;

    always_comb begin
        state_nxt = state;
        win       = 1'b0;
        rd_cap    = 1'b0;
        to_cap    = 1'b0;
        case (state)
            IDLE: begin
                if (v0 || v1) state_nxt = ISSUE;
                // On a tie the requester that was not served last goes next
                win = (v0 && v1) ? ~last : v1;
            end
            ISSUE: begin
                if (bus_ready) begin
                    rd_cap    = 1'b1;
                    state_nxt = DONE;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus_ready) begin
                    rd_cap    = 1'b1;
                    state_nxt = DONE;
                end else if (cnt == CNT_LIMIT) begin
                    to_cap    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus_transfer = (state == ISSUE);
    assign m0_ready     = (state == DONE) && !gnt;
    assign m1_ready     = (state == DONE) && gnt;
    assign clr0         = m0_ready;
    assign clr1         = m1_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            gnt       <= 1'b0;
            last      <= 1'b1;
            v0        <= 1'b0;
            v1        <= 1'b0;
            w0        <= 1'b0;
            w1        <= 1'b0;
            a0        <= '0;
            a1        <= '0;
            d0        <= '0;
            d1        <= '0;
            bus_write <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            err       <= 1'b0;
            err_id    <= 1'b0;
        end else begin
            state <= state_nxt;

            // A pulse in the completion cycle refills the slot being freed
            if (m0_transfer && (!v0 || clr0)) begin
                v0 <= 1'b1;
                w0 <= m0_write;
                a0 <= m0_addr;
                d0 <= m0_wdata;
            end else if (clr0) begin
                v0 <= 1'b0;
            end
            if (m1_transfer && (!v1 || clr1)) begin
                v1 <= 1'b1;
                w1 <= m1_write;
                a1 <= m1_addr;
                d1 <= m1_wdata;
            end else if (clr1) begin
                v1 <= 1'b0;
            end

            if (state == IDLE && state_nxt == ISSUE) begin
                gnt       <= win;
                bus_write <= win ? w1 : w0;
                bus_addr  <= win ? a1 : a0;
                bus_wdata <= win ? d1 : d0;
            end

            if (state == ISSUE) begin
                cnt <= CW'(1);
            end else if (state == WAIT && cnt != '1) begin
                cnt <= cnt + CW'(1);
            end

            if (rd_cap || to_cap) begin
                if (gnt) m1_rdata <= rd_cap ? bus_rdata : ERR_DATA;
                else     m0_rdata <= rd_cap ? bus_rdata : ERR_DATA;
            end

            if (err_clr) begin
                err    <= 1'b0;
                err_id <= 1'b0;
            end else if (to_cap) begin
                err    <= 1'b1;
                err_id <= gnt;
            end

            if (state == DONE) last <= gnt;
        end
    end

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Scoreboard bench for apb_bus_arbiter. Directed stimulus pushes expected bus
// issues and completions; a negedge monitor pops and compares them.
module tb_apb_bus_arbiter;

    logic        clk, reset;
    logic        m0_transfer, m0_write, m0_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_transfer, m1_write, m1_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        bus_transfer, bus_write, bus_ready;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        err_clr, err, err_id;

    apb_bus_arbiter #(.TIMEOUT(16), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .reset(reset),
        .m0_transfer(m0_transfer), .m0_write(m0_write), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_transfer(m1_transfer), .m1_write(m1_write), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .bus_transfer(bus_transfer), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .err_clr(err_clr), .err(err), .err_id(err_id)
    );

    typedef struct {int cyc; logic w; logic [31:0] a; logic [31:0] d;} bus_e;
    typedef struct {int cyc; logic id; logic [31:0] d;} rdy_e;

    bus_e bus_q[$];
    rdy_e rdy_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DUT presentation is matched against the head of its queue
    always @(negedge clk) begin
        bus_e be;
        rdy_e re;
        if (bus_transfer === 1'b1) begin
            if (bus_q.size() == 0) begin
                chk("bus_unexpected", 32'd1, 32'd0);
            end else begin
                be = bus_q.pop_front();
                chk("bus_cycle", 32'(cyc), 32'(be.cyc));
                chk("bus_write", {31'd0, bus_write}, {31'd0, be.w});
                chk("bus_addr", bus_addr, be.a);
                chk("bus_wdata", bus_wdata, be.d);
            end
        end
        if (m0_ready === 1'b1 || m1_ready === 1'b1) begin
            chk("ready_onehot", 32'(m0_ready) + 32'(m1_ready), 32'd1);
            if (rdy_q.size() == 0) begin
                chk("ready_unexpected", 32'd1, 32'd0);
            end else begin
                re = rdy_q.pop_front();
                chk("ready_cycle", 32'(cyc), 32'(re.cyc));
                chk("ready_id", {31'd0, m1_ready}, {31'd0, re.id});
                chk("ready_rdata", re.id ? m1_rdata : m0_rdata, re.d);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        m0_transfer = 1'b0;
        m1_transfer = 1'b0;
        err_clr     = 1'b0;
    endtask

    task automatic drive0(input logic w, input logic [31:0] a, input logic [31:0] d);
        m0_transfer = 1'b1; m0_write = w; m0_addr = a; m0_wdata = d;
    endtask

    task automatic drive1(input logic w, input logic [31:0] a, input logic [31:0] d);
        m1_transfer = 1'b1; m1_write = w; m1_addr = a; m1_wdata = d;
    endtask

    task automatic expect_bus(input int c, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus_q.push_back('{cyc: c, w: w, a: a, d: d});
    endtask

    // Called in the ISSUE cycle; slave answers lat cycles later; returns in DONE
    task automatic serve(input logic id, input int lat, input logic [31:0] data);
        rdy_q.push_back('{cyc: cyc + lat + 1, id: id, d: data});
        repeat (lat) step();
        bus_ready = 1'b1;
        bus_rdata = data;
        step();
        bus_ready = 1'b0;
        bus_rdata = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_bus_transfer"}, {31'd0, bus_transfer}, 32'd0);
        chk({tag, "_bus_write"}, {31'd0, bus_write}, 32'd0);
        chk({tag, "_bus_addr"}, bus_addr, 32'd0);
        chk({tag, "_bus_wdata"}, bus_wdata, 32'd0);
        chk({tag, "_ready"}, {30'd0, m1_ready, m0_ready}, 32'd0);
        chk({tag, "_m0_rdata"}, m0_rdata, 32'd0);
        chk({tag, "_m1_rdata"}, m1_rdata, 32'd0);
        chk({tag, "_err"}, {30'd0, err_id, err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, t;
        reset = 1'b0; err_clr = 1'b0; bus_ready = 1'b0; bus_rdata = '0;
        m0_transfer = 1'b0; m0_write = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_transfer = 1'b0; m1_write = 1'b0; m1_addr = '0; m1_wdata = '0;
        step(); step();
        check_all_zero("reset");
        reset = 1'b1;
        step();

        // Single read from m0
        n = cyc;
        drive0(1'b0, 32'h1000_0000, 32'h0000_0055);
        expect_bus(n + 2, 1'b0, 32'h1000_0000, 32'h0000_0055);
        step(); step();
        serve(1'b0, 2, 32'h1234_5678);
        step();

        // Simultaneous pair right after reset: m0 first
        reset = 1'b0; step(); reset = 1'b1; step();
        n = cyc;
        drive0(1'b1, 32'h1000_1000, 32'h0000_000A);
        drive1(1'b1, 32'h1000_2000, 32'h0000_000B);
        expect_bus(n + 2, 1'b1, 32'h1000_1000, 32'h0000_000A);
        step(); step();
        serve(1'b0, 1, 32'h0000_0011);
        expect_bus(n + 6, 1'b1, 32'h1000_2000, 32'h0000_000B);
        step(); step();
        serve(1'b1, 1, 32'h0000_0022);
        step();

        // Lone m0 makes last = 0, so the following tie goes to m1
        n = cyc;
        drive0(1'b0, 32'h1000_3000, 32'h0);
        expect_bus(n + 2, 1'b0, 32'h1000_3000, 32'h0);
        step(); step();
        serve(1'b0, 1, 32'h0000_0044);
        step();
        n = cyc;
        drive0(1'b1, 32'h1000_4000, 32'h0000_000C);
        drive1(1'b1, 32'h1000_5000, 32'h0000_000D);
        expect_bus(n + 2, 1'b1, 32'h1000_5000, 32'h0000_000D);
        step(); step();
        serve(1'b1, 0, 32'h0000_0055);
        expect_bus(n + 5, 1'b1, 32'h1000_4000, 32'h0000_000C);
        step(); step();
        serve(1'b0, 0, 32'h0000_0066);
        step();

        // Duplicate m1 pulse while pending is dropped
        n = cyc;
        drive1(1'b0, 32'h2000_0000, 32'h0);
        expect_bus(n + 2, 1'b0, 32'h2000_0000, 32'h0);
        step();
        drive1(1'b1, 32'h2000_0F00, 32'hFFFF_FFFF);
        step();
        serve(1'b1, 3, 32'h0000_0033);
        repeat (6) step();

        // m0 timeout
        n = cyc;
        drive0(1'b0, 32'h3000_0000, 32'h0);
        expect_bus(n + 2, 1'b0, 32'h3000_0000, 32'h0);
        step(); step();
        t = cyc;
        rdy_q.push_back('{cyc: t + 17, id: 1'b0, d: 32'hDEAD_BEEF});
        repeat (17) step();
        chk("timeout0_err", {31'd0, err}, 32'd1);
        chk("timeout0_err_id", {31'd0, err_id}, 32'd0);
        step();
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        repeat (3) step();
        chk("late_ready_err_kept", {31'd0, err}, 32'd1);

        // m1 timeout updates err_id
        n = cyc;
        drive1(1'b0, 32'h3000_0100, 32'h0);
        expect_bus(n + 2, 1'b0, 32'h3000_0100, 32'h0);
        step(); step();
        t = cyc;
        rdy_q.push_back('{cyc: t + 17, id: 1'b1, d: 32'hDEAD_BEEF});
        repeat (17) step();
        chk("timeout1_err_id", {31'd0, err_id}, 32'd1);
        step();
        err_clr = 1'b1;
        step();
        chk("err_clr_err", {31'd0, err}, 32'd0);
        chk("err_clr_err_id", {31'd0, err_id}, 32'd0);

        // err_clr coinciding with the timeout wins
        n = cyc;
        drive0(1'b0, 32'h3000_0200, 32'h0);
        expect_bus(n + 2, 1'b0, 32'h3000_0200, 32'h0);
        step(); step();
        t = cyc;
        rdy_q.push_back('{cyc: t + 17, id: 1'b0, d: 32'hDEAD_BEEF});
        repeat (16) step();
        err_clr = 1'b1;
        step();
        chk("clr_priority_err", {31'd0, err}, 32'd0);
        step();

        // Reset while in WAIT abandons the transfer
        n = cyc;
        drive0(1'b0, 32'h4000_0000, 32'h0);
        expect_bus(n + 2, 1'b0, 32'h4000_0000, 32'h0);
        step(); step(); step(); step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_all_zero("midreset");
        repeat (5) step();
        n = cyc;
        drive1(1'b1, 32'h5000_0000, 32'h0000_0077);
        expect_bus(n + 2, 1'b1, 32'h5000_0000, 32'h0000_0077);
        step(); step();
        serve(1'b1, 2, 32'h0000_0088);
        step();

        // New m0 pulse in its own completion cycle reloads the slot
        n = cyc;
        drive0(1'b0, 32'h6000_0000, 32'h0);
        expect_bus(n + 2, 1'b0, 32'h6000_0000, 32'h0);
        step(); step();
        serve(1'b0, 1, 32'h0000_0099);
        n = cyc;
        drive0(1'b1, 32'h6000_0004, 32'h0000_00AB);
        expect_bus(n + 2, 1'b1, 32'h6000_0004, 32'h0000_00AB);
        step(); step();
        serve(1'b0, 1, 32'h0000_00BC);
        repeat (6) step();

        chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        chk("ready_queue_drained", 32'(rdy_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
